// File: rtl/oc8051_uart_peer_if.sv
// Byte-side handshake bundle for oc8051_uart_peer.
// master = host logic feeding/draining bytes, slave = the serial peer.
interface oc8051_uart_peer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [8:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [8:0] rx_data;
    logic       rx_ferr;
    logic       rx_overrun;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_ferr, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_ferr, rx_overrun
    );
endinterface

// File: rtl/oc8051_uart_peer.sv
// Serial peer for the oc8051 UART: 8/9-bit async transmitter and 16x oversampled receiver
// sharing one run-time programmable oversample tick generator.
module oc8051_uart_peer #(
    parameter int DIV_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              nine_bit,
    output logic              txd,
    input  logic              rxd,
    oc8051_uart_peer_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // >= compare keeps a lowered divisor from forcing a full counter wrap
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        tick  = (cnt_q >= baud_div);
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    state_t     tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [8:0] tx_shift_q, tx_shift_d;
    logic       tx_nine_q, tx_nine_d;
    logic       txd_q, txd_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_nine_d  = tx_nine_q;
        txd_d      = txd_q;
        if (tx_state_q == ST_IDLE) begin
            if (bus.tx_valid) begin
                tx_state_d = ST_START;
                tx_shift_d = bus.tx_data;
                tx_nine_d  = nine_bit;
                tx_tcnt_d  = 4'd0;
                tx_bit_d   = 4'd0;
                txd_d      = 1'b0;
            end
        end else if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                case (tx_state_q)
                    ST_START: begin
                        tx_state_d = ST_DATA;
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                    ST_DATA: begin
                        if (tx_bit_q == (tx_nine_q ? 4'd8 : 4'd7)) begin
                            tx_state_d = ST_STOP;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 4'd1;
                            txd_d      = tx_shift_q[0];
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end
                    default: begin
                        tx_state_d = ST_IDLE;
                        txd_d      = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_tcnt_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= 9'd0;
            tx_nine_q  <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_nine_q  <= tx_nine_d;
            txd_q      <= txd_d;
        end
    end

    assign txd          = txd_q;
    assign bus.tx_ready = (tx_state_q == ST_IDLE);

    state_t     rx_state_q, rx_state_d;
    logic       rx_s1_q, rx_s2_q, rx_prev_q;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [8:0] rx_shift_q, rx_shift_d;
    logic       rx_nine_q, rx_nine_d;
    logic [1:0] rx_smp_q, rx_smp_d;
    logic       rx_valid_q, rx_valid_d;
    logic [8:0] rx_data_q, rx_data_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       vote, frame_done;

    // Samples from ticks 7 and 8 are held; the live synced value is the third vote at tick 9
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_nine_d  = rx_nine_q;
        rx_smp_d   = rx_smp_q;
        rx_data_d  = rx_data_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = rx_valid_q & ~bus.rx_ready;
        rx_ovr_d   = 1'b0;
        frame_done = 1'b0;
        vote = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) | (rx_smp_q[1] & rx_s2_q);
        if (rx_state_q == ST_IDLE) begin
            if (rx_prev_q & ~rx_s2_q) begin
                rx_state_d = ST_START;
                rx_tcnt_d  = 4'd0;
                rx_bit_d   = 4'd0;
                rx_shift_d = 9'd0;
                rx_nine_d  = nine_bit;
            end
        end else if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd7) rx_smp_d[0] = rx_s2_q;
            if (rx_tcnt_q == 4'd8) rx_smp_d[1] = rx_s2_q;
            if (rx_tcnt_q == 4'd9) begin
                case (rx_state_q)
                    ST_START: if (vote) rx_state_d = ST_IDLE;
                    ST_DATA:  rx_shift_d[rx_bit_q] = vote;
                    default: begin
                        frame_done = 1'b1;
                        rx_state_d = ST_IDLE;
                    end
                endcase
            end
            if (rx_tcnt_q == 4'd15) begin
                if (rx_state_q == ST_START) begin
                    rx_state_d = ST_DATA;
                end else if (rx_state_q == ST_DATA) begin
                    if (rx_bit_q == (rx_nine_q ? 4'd8 : 4'd7)) rx_state_d = ST_STOP;
                    else                                        rx_bit_d   = rx_bit_q + 4'd1;
                end
            end
        end
        if (frame_done) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = rx_nine_q ? rx_shift_q : {1'b0, rx_shift_q[7:0]};
                rx_ferr_d  = ~vote;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= 9'd0;
            rx_nine_q  <= 1'b0;
            rx_smp_q   <= 2'b11;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 9'd0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_nine_q  <= rx_nine_d;
            rx_smp_q   <= rx_smp_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_ferr    = rx_ferr_q;
    assign bus.rx_overrun = rx_ovr_q;
endmodule

// File: tb/tb_oc8051_uart_peer.sv
// Self-checking bench for oc8051_uart_peer: queue-based frame model checked every cycle,
// directed frame scenarios with literal expectations, then randomized loopback and driven frames.
`timescale 1ns/1ps
module tb_oc8051_uart_peer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        nine_bit = 1'b0;
    logic        txd;
    logic        rxd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;

    oc8051_uart_peer_if bus();

    assign rxd = loop_en ? txd : rxd_drv;

    oc8051_uart_peer #(.DIV_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .nine_bit (nine_bit),
        .txd      (txd),
        .rxd      (rxd),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: the serial line is a queue of bit values, each held for 16 ticks
    int         cyc = 0;
    bit         m_busy = 0;
    bit         m_bits[$];
    int         m_ticks = 0;
    logic [9:0] exp_rx_q[$];
    bit         prev_valid = 0, prev_ready = 0, prev_ovr = 0;
    logic [8:0] last_data = '0;
    logic       last_ferr = 1'b0;
    int         frames_seen = 0;
    int         ovr_count = 0;
    bit         ovr_allow = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] e;
        bit         tk;
        bit         load;
        if (rst) begin
            m_busy  = 0;
            m_bits.delete();
            m_ticks = 0;
            cyc     = 0;
            checkOutput("reset_txd", txd, 1);
            checkOutput("reset_tx_ready", bus.tx_ready, 1);
            checkOutput("reset_rx_valid", bus.rx_valid, 0);
            checkOutput("reset_rx_data", bus.rx_data, 0);
            checkOutput("reset_rx_ferr", bus.rx_ferr, 0);
            checkOutput("reset_rx_overrun", bus.rx_overrun, 0);
            prev_valid = 0;
            prev_ready = 0;
            prev_ovr   = 0;
        end else begin
            checkOutput("txd", txd, m_busy ? m_bits[0] : 1'b1);
            checkOutput("tx_ready", bus.tx_ready, !m_busy);
            load = bus.rx_valid && !(prev_valid && !prev_ready);
            if (load) begin
                frames_seen++;
                if (exp_rx_q.size() == 0) begin
                    checkOutput("rx_unexpected_frame", bus.rx_valid, 0);
                end else begin
                    e = exp_rx_q.pop_front();
                    checkOutput("rx_data", bus.rx_data, e[8:0]);
                    checkOutput("rx_ferr", bus.rx_ferr, e[9]);
                end
                last_data = bus.rx_data;
                last_ferr = bus.rx_ferr;
            end else if (bus.rx_valid) begin
                checkOutput("rx_data_hold", bus.rx_data, last_data);
            end
            if (!ovr_allow) begin
                checkOutput("rx_overrun_quiet", bus.rx_overrun, 0);
            end else if (bus.rx_overrun) begin
                ovr_count++;
                checkOutput("rx_overrun_width", prev_ovr, 0);
            end
            prev_valid = bus.rx_valid;
            prev_ready = bus.rx_ready;
            prev_ovr   = bus.rx_overrun;

            tk = ((cyc % (int'(baud_div) + 1)) == int'(baud_div));
            cyc++;
            if (m_busy) begin
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == 16) begin
                        m_ticks = 0;
                        void'(m_bits.pop_front());
                        if (m_bits.size() == 0) m_busy = 0;
                    end
                end
            end else if (bus.tx_valid) begin
                m_busy  = 1;
                m_ticks = 0;
                m_bits.push_back(1'b0);
                for (int i = 0; i < (nine_bit ? 9 : 8); i++) m_bits.push_back(bus.tx_data[i]);
                m_bits.push_back(1'b1);
                if (loop_en)
                    exp_rx_q.push_back({1'b0, nine_bit ? bus.tx_data : {1'b0, bus.tx_data[7:0]}});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int div);
        step(1);
        rst          = 1'b1;
        baud_div     = 16'(div);
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b1;
        rxd_drv      = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget);
        int n = 0;
        while (!bus.tx_ready && n < budget) begin
            step(1);
            n++;
        end
        if (!bus.tx_ready) checkOutput("tx_idle_timeout", bus.tx_ready, 1);
    endtask

    task automatic wait_rx_drain(input int budget);
        int n = 0;
        while (exp_rx_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        if (exp_rx_q.size() != 0) begin
            checkOutput("rx_frame_timeout", exp_rx_q.size(), 0);
            exp_rx_q.delete();
        end
    endtask

    task automatic applyStimulus(input logic [8:0] data, input bit nine);
        wait_tx_idle(3000);
        nine_bit     = nine;
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    // Records txd at the centre of each bit slot (baud_div=0 only) and the tx_ready low window
    task automatic capture_frame(input logic [8:0] data, input bit nine, input bit hold,
                                 output logic [10:0] cap, output int low_cnt, output logic rdy_after);
        logic rdy[200];
        int   nslots;
        bit   counting;
        nslots       = nine ? 11 : 10;
        cap          = '0;
        nine_bit     = nine;
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.tx_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((i % 16) == 7 && (i / 16) < nslots) cap[i / 16] = txd;
            rdy[i] = bus.tx_ready;
        end
        low_cnt  = 0;
        counting = 1;
        for (int i = 0; i < 200; i++) begin
            if (counting && !rdy[i]) low_cnt++;
            else counting = 0;
        end
        rdy_after = (low_cnt < 199) ? rdy[low_cnt + 1] : 1'bx;
        step(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [8:0] data, input bit nine, input bit stop,
                                  input int glitch_bit, input bit expect_frame);
        int bt;
        int tkc;
        tkc = int'(baud_div) + 1;
        bt  = 16 * tkc;
        nine_bit = nine;
        if (expect_frame)
            exp_rx_q.push_back({!stop, nine ? data : {1'b0, data[7:0]}});
        rxd_drv = 1'b0;
        step(bt);
        for (int i = 0; i < (nine ? 9 : 8); i++) begin
            rxd_drv = data[i];
            if (glitch_bit == i) begin
                step(8 * tkc);
                rxd_drv = ~data[i];
                step(tkc);
                rxd_drv = data[i];
                step(bt - 9 * tkc);
            end else begin
                step(bt);
            end
        end
        rxd_drv = stop;
        step(bt);
        rxd_drv = 1'b1;
        step(bt);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] cap;
        int          low_cnt;
        logic        rdy_after;
        int          seen0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b1;
        step(3);
        rst = 1'b0;

        $display("[TB] directed TX framing, baud_div=0");
        apply_reset(0);
        capture_frame(9'h0A5, 1'b0, 1'b0, cap, low_cnt, rdy_after);
        checkOutput("t1_frame_bits", cap, 11'h34A);
        checkOutput("t1_ready_low_cycles", low_cnt, 160);
        wait_tx_idle(1000);
        capture_frame(9'h13C, 1'b1, 1'b1, cap, low_cnt, rdy_after);
        checkOutput("t2_frame_bits", cap, 11'h678);
        checkOutput("t2_ready_low_cycles", low_cnt, 176);
        checkOutput("t2_back_to_back", rdy_after, 0);
        wait_tx_idle(1000);

        $display("[TB] loopback, baud_div=3");
        loop_en = 1'b1;
        apply_reset(3);
        applyStimulus(9'h05A, 1'b0);
        wait_rx_drain(2000);
        checkOutput("t3_rx_data_8bit", last_data, 9'h05A);
        checkOutput("t3_rx_ferr_8bit", last_ferr, 0);
        applyStimulus(9'h1FF, 1'b1);
        wait_rx_drain(2000);
        checkOutput("t3_rx_data_9bit", last_data, 9'h1FF);
        wait_tx_idle(2000);
        loop_en = 1'b0;

        $display("[TB] false start, glitch, framing error");
        seen0   = frames_seen;
        step(1);
        rxd_drv = 1'b0;
        step(4 * 4);
        rxd_drv = 1'b1;
        step(200);
        checkOutput("t4_false_start_frames", frames_seen - seen0, 0);
        drive_rx_frame(9'h000, 1'b0, 1'b1, 3, 1'b1);
        wait_rx_drain(100);
        checkOutput("t4_glitch_data", last_data, 9'h000);
        drive_rx_frame(9'h033, 1'b0, 1'b0, -1, 1'b1);
        wait_rx_drain(100);
        checkOutput("t5_ferr_data", last_data, 9'h033);
        checkOutput("t5_ferr_flag", last_ferr, 1);

        $display("[TB] overrun and mid-frame reset");
        apply_reset(1);
        bus.rx_ready = 1'b0;
        ovr_count    = 0;
        ovr_allow    = 1'b1;
        drive_rx_frame(9'h041, 1'b0, 1'b1, -1, 1'b1);
        drive_rx_frame(9'h042, 1'b0, 1'b1, -1, 1'b0);
        step(4);
        checkOutput("t6_overrun_pulses", ovr_count, 1);
        checkOutput("t6_rx_valid_held", bus.rx_valid, 1);
        checkOutput("t6_rx_data_kept", bus.rx_data, 9'h041);
        bus.rx_ready = 1'b1;
        step(2);
        checkOutput("t6_rx_valid_cleared", bus.rx_valid, 0);
        ovr_allow = 1'b0;
        applyStimulus(9'h0F0, 1'b0);
        step(50);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_txd", txd, 1);
        checkOutput("t6_rst_tx_ready", bus.tx_ready, 1);
        step(2);
        rst = 1'b0;

        $display("[TB] randomized sessions");
        for (int s = 0; s < 4; s++) begin
            apply_reset($urandom_range(0, 3));
            loop_en = 1'b1;
            for (int f = 0; f < 5; f++)
                applyStimulus(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            wait_tx_idle(3000);
            wait_rx_drain(100);
            loop_en = 1'b0;
            for (int f = 0; f < 4; f++) begin
                int g;
                bit nb;
                nb = 1'($urandom_range(0, 1));
                g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nb ? 8 : 7)) : -1;
                drive_rx_frame(9'($urandom_range(0, 511)), nb, 1'($urandom_range(0, 3) != 0), g, 1'b1);
                wait_rx_drain(100);
            end
        end

        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
